da_array_sched: RTL and testbench



---
 rtl/da_sched_pkg.sv | 21 ++
 rtl/da_res_fifo.sv | 65 ++++++
 rtl/da_array_sched.sv | 156 +++++++++++++++
 tb/tb_da_array_sched.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/da_sched_pkg.sv
// rtl/da_sched_pkg.sv - shared types and helpers for the DA array job scheduler
//
// Contents:
//   sched_state_t : controller state (IDLE, CLR, RUN, TAIL)
//   row_width()   : default row-tag width, max(1, clog2(rows))
// The result entry {data, row} is sized by the top-level parameters.
// It is therefore declared as a packed struct inside da_array_sched.
package da_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    TAIL = 2'd3
  } sched_state_t;

  function automatic int row_width(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/da_res_fifo.sv
// rtl/da_res_fifo.sv - synchronous result FIFO with registered storage
//
// Ports:
//   clk, rst          : clock, asynchronous active-low reset (flushes contents)
//   push, push_data   : write request and payload
//   pop               : read request; ignored when empty
//   head              : entry at the read pointer
//   full, empty       : occupancy flags
//   count             : number of stored entries
// A push while full is accepted only when a pop happens in the same cycle.
module da_res_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW + 1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/da_array_sched.sv
// rtl/da_array_sched.sv - job controller for the bit-serial DA array
//
// Ports:
//   clk, rst                : clock, asynchronous active-low reset
//   start, bias_cfg         : job request (IDLE only), bias enable for the job
//   busy, done              : job in progress, one-cycle end-of-job pulse
//   arr_rst                 : active-high clear to the array (CLR state or reset)
//   arr_gen_done            : array advance strobe
//   arr_bias_en             : bias enable latched at accept
//   arr_final_out           : array result vector (N x DATA_WIDTH_output)
//   res_valid, res_ready    : result FIFO handshake
//   res_data, res_row       : FIFO head data and its row index
module da_array_sched
  import da_sched_pkg::*;
#(
  parameter int DATA_WIDTH_A      = 8,
  parameter int DATA_WIDTH_output = 8,
  parameter int M                 = 1,
  parameter int N                 = 1,
  parameter int FIFO_DEPTH        = 4,
  parameter int ROW_W             = row_width(M)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                bias_cfg,
  output logic                                busy,
  output logic                                done,
  output logic                                arr_rst,
  output logic                                arr_gen_done,
  output logic                                arr_bias_en,
  input  logic signed [N*DATA_WIDTH_output-1:0] arr_final_out,
  output logic                                res_valid,
  input  logic                                res_ready,
  output logic signed [N*DATA_WIDTH_output-1:0] res_data,
  output logic [ROW_W-1:0]                    res_row
);

  localparam int RW = N * DATA_WIDTH_output;
  localparam int TW = (DATA_WIDTH_A > 1) ? $clog2(DATA_WIDTH_A) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0]    T_LAST = TW'(DATA_WIDTH_A - 1);
  localparam logic [ROW_W-1:0] M_LAST = ROW_W'(M - 1);

  typedef struct packed {
    logic [RW-1:0]    data;
    logic [ROW_W-1:0] row;
  } res_entry_t;

  sched_state_t     state_q, state_d;
  logic [TW-1:0]    t_q;
  logic [ROW_W-1:0] m_q;

  logic             capture_due;
  logic             stall;
  logic             gen;
  logic             push;
  logic [ROW_W-1:0] cap_row;
  res_entry_t       push_e;
  res_entry_t       head_e;

  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [CW-1:0]    fifo_count;

  assign fifo_pop = res_ready && !fifo_empty;

  // A capture is due on a row boundary once a row has finished.
  // In TAIL the last row is always pending.
  // The stall only blocks that boundary when no slot frees up this cycle.
  always_comb begin
    state_d     = state_q;
    capture_due = 1'b0;
    stall       = 1'b0;
    gen         = 1'b0;
    cap_row     = m_q - ROW_W'(1);
    case (state_q)
      IDLE: begin
        if (start) state_d = CLR;
      end
      CLR: begin
        state_d = RUN;
      end
      RUN: begin
        capture_due = (t_q == '0) && (m_q != '0);
        stall       = capture_due && fifo_full && !fifo_pop;
        gen         = !stall;
        if (gen && (t_q == T_LAST) && (m_q == M_LAST)) state_d = TAIL;
      end
      TAIL: begin
        capture_due = 1'b1;
        cap_row     = M_LAST;
        stall       = fifo_full && !fifo_pop;
        gen         = !stall;
        if (gen) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    push = capture_due && gen;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      t_q         <= '0;
      m_q         <= '0;
      arr_bias_en <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= (state_q == TAIL) && gen;
      if (state_q == IDLE) begin
        if (start) begin
          arr_bias_en <= bias_cfg;
          t_q         <= '0;
          m_q         <= '0;
        end
      end else if (gen) begin
        // m stops at the last row; TAIL reports that row explicitly.
        if (t_q == T_LAST) begin
          t_q <= '0;
          if ((state_q == RUN) && (m_q != M_LAST)) m_q <= m_q + ROW_W'(1);
        end else begin
          t_q <= t_q + TW'(1);
        end
      end
    end
  end

  assign push_e.data = arr_final_out;
  assign push_e.row  = cap_row;

  da_res_fifo #(
    .WIDTH ($bits(res_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_e),
    .pop       (fifo_pop),
    .head      (head_e),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign busy         = (state_q != IDLE);
  assign arr_rst      = !rst || (state_q == CLR);
  assign arr_gen_done = gen;
  assign res_valid    = (fifo_count != '0);
  assign res_data     = head_e.data;
  assign res_row      = head_e.row;

endmodule

// File: tb/tb_da_array_sched.sv
// tb/tb_da_array_sched.sv - scoreboard bench for da_array_sched
module tb_da_array_sched;

  typedef struct {
    int data;
    int row;
  } exp_t;

  logic clk;
  logic rst_n;
  logic bias_cfg;
  logic start_a, start_b, start_c;
  logic rdy_a, rdy_b, rdy_c;

  logic busy_a, done_a, arr_rst_a, gd_a, bias_en_a, res_valid_a;
  logic busy_b, done_b, arr_rst_b, gd_b, bias_en_b, res_valid_b;
  logic busy_c, done_c, arr_rst_c, gd_c, bias_en_c, res_valid_c;
  logic signed [7:0] fo_a, fo_b, fo_c;
  logic signed [7:0] res_data_a, res_data_b, res_data_c;
  logic [0:0] res_row_a;
  logic [1:0] res_row_b;
  logic [0:0] res_row_c;

  int n_checks = 0;
  int n_errors = 0;
  exp_t exp_q_a[$];
  exp_t exp_q_b[$];
  exp_t exp_q_c[$];

  logic [63:0] rst_tr, gd_tr, done_tr, val_tr, busy_tr, bias_tr;

  da_array_sched #(.DATA_WIDTH_A(8), .DATA_WIDTH_output(8), .M(2), .N(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst(rst_n), .start(start_a), .bias_cfg(bias_cfg), .busy(busy_a), .done(done_a),
    .arr_rst(arr_rst_a), .arr_gen_done(gd_a), .arr_bias_en(bias_en_a), .arr_final_out(fo_a),
    .res_valid(res_valid_a), .res_ready(rdy_a), .res_data(res_data_a), .res_row(res_row_a));

  da_array_sched #(.DATA_WIDTH_A(8), .DATA_WIDTH_output(8), .M(4), .N(1), .FIFO_DEPTH(2)) u_b (
    .clk(clk), .rst(rst_n), .start(start_b), .bias_cfg(bias_cfg), .busy(busy_b), .done(done_b),
    .arr_rst(arr_rst_b), .arr_gen_done(gd_b), .arr_bias_en(bias_en_b), .arr_final_out(fo_b),
    .res_valid(res_valid_b), .res_ready(rdy_b), .res_data(res_data_b), .res_row(res_row_b));

  da_array_sched #(.DATA_WIDTH_A(8), .DATA_WIDTH_output(8), .M(1), .N(1), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .rst(rst_n), .start(start_c), .bias_cfg(bias_cfg), .busy(busy_c), .done(done_c),
    .arr_rst(arr_rst_c), .arr_gen_done(gd_c), .arr_bias_en(bias_en_c), .arr_final_out(fo_c),
    .res_valid(res_valid_c), .res_ready(rdy_c), .res_data(res_data_c), .res_row(res_row_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array models: t/m counters cleared by arr_rst, advanced by gen_done.
  // At t==0 each model presents 10*m, i.e. 10*(row+1) for the row just finished.
  int am_a, at_a, am_b, at_b, am_c, at_c;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin am_a <= 0; at_a <= 0; end
    else if (arr_rst_a) begin am_a <= 0; at_a <= 0; end
    else if (gd_a) begin
      if (at_a == 7) begin at_a <= 0; am_a <= am_a + 1; end else at_a <= at_a + 1;
    end
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin am_b <= 0; at_b <= 0; end
    else if (arr_rst_b) begin am_b <= 0; at_b <= 0; end
    else if (gd_b) begin
      if (at_b == 7) begin at_b <= 0; am_b <= am_b + 1; end else at_b <= at_b + 1;
    end
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin am_c <= 0; at_c <= 0; end
    else if (arr_rst_c) begin am_c <= 0; at_c <= 0; end
    else if (gd_c) begin
      if (at_c == 7) begin at_c <= 0; am_c <= am_c + 1; end else at_c <= at_c + 1;
    end
  assign fo_a = 8'(10 * am_a);
  assign fo_b = 8'(10 * am_b);
  assign fo_c = 8'(10 * am_c);

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted FIFO head is compared against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && res_valid_a && rdy_a) begin
      if (exp_q_a.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL sb_a_extra: got data %0d expected no entry", res_data_a);
      end else begin
        e = exp_q_a.pop_front();
        check("sb_a_data", int'(res_data_a), e.data);
        check("sb_a_row", int'(res_row_a), e.row);
      end
    end
    if (rst_n && res_valid_b && rdy_b) begin
      if (exp_q_b.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL sb_b_extra: got data %0d expected no entry", res_data_b);
      end else begin
        e = exp_q_b.pop_front();
        check("sb_b_data", int'(res_data_b), e.data);
        check("sb_b_row", int'(res_row_b), e.row);
      end
    end
    if (rst_n && res_valid_c && rdy_c) begin
      if (exp_q_c.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL sb_c_extra: got data %0d expected no entry", res_data_c);
      end else begin
        e = exp_q_c.pop_front();
        check("sb_c_data", int'(res_data_c), e.data);
        check("sb_c_row", int'(res_row_c), e.row);
      end
    end
  end

  function automatic int first_one(input logic [63:0] v);
    for (int i = 0; i < 64; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int last_one(input logic [63:0] v);
    for (int i = 63; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0:       start_a = v;
      1:       start_b = v;
      default: start_c = v;
    endcase
  endtask

  task automatic sample(input int sel, input int c);
    case (sel)
      0: begin
        rst_tr[c] = arr_rst_a; gd_tr[c] = gd_a; done_tr[c] = done_a;
        val_tr[c] = res_valid_a; busy_tr[c] = busy_a; bias_tr[c] = bias_en_a;
      end
      1: begin
        rst_tr[c] = arr_rst_b; gd_tr[c] = gd_b; done_tr[c] = done_b;
        val_tr[c] = res_valid_b; busy_tr[c] = busy_b; bias_tr[c] = bias_en_b;
      end
      default: begin
        rst_tr[c] = arr_rst_c; gd_tr[c] = gd_c; done_tr[c] = done_c;
        val_tr[c] = res_valid_c; busy_tr[c] = busy_c; bias_tr[c] = bias_en_c;
      end
    endcase
  endtask

  // Cycle 0 is the accept cycle. Inputs change 1 time unit after each rising edge.
  // Outputs are sampled on the falling edge.
  task automatic run_trace(input int sel, input int ncyc, input int again_at, input int tog_at);
    rst_tr = '0; gd_tr = '0; done_tr = '0; val_tr = '0; busy_tr = '0; bias_tr = '0;
    @(negedge clk);
    set_start(sel, 1'b1);
    sample(sel, 0);
    for (int c = 1; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      set_start(sel, c == again_at);
      if (sel == 1) rdy_b = (c == 30) || (c >= 40);
      if (c == tog_at) bias_cfg = !bias_cfg;
      @(negedge clk);
      sample(sel, c);
    end
  endtask

  task automatic check_std_a(input string tag);
    check({tag, "_arr_rst_cycle"}, first_one(rst_tr), 1);
    check({tag, "_arr_rst_count"}, $countones(rst_tr), 1);
    check({tag, "_gd_first"}, first_one(gd_tr), 2);
    check({tag, "_gd_last"}, last_one(gd_tr), 18);
    check({tag, "_gd_count"}, $countones(gd_tr), 17);
    check({tag, "_done_cycle"}, first_one(done_tr), 19);
    check({tag, "_done_count"}, $countones(done_tr), 1);
    check({tag, "_valid_first"}, first_one(val_tr), 11);
    check({tag, "_busy_count"}, $countones(busy_tr), 18);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; bias_cfg = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    rdy_a = 1'b1; rdy_b = 1'b0; rdy_c = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy_a, 0);
    check("reset_arr_rst", arr_rst_a, 1);
    check("reset_gen_done", gd_a, 0);
    check("reset_res_valid", res_valid_a, 0);
    check("reset_res_data", int'(res_data_a), 0);
    check("reset_bias_en", bias_en_a, 0);
    check("reset_done", done_a, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Job 1: plain M=2 job.
    exp_q_a.push_back(exp_t'{10, 0});
    exp_q_a.push_back(exp_t'{20, 1});
    run_trace(0, 22, -1, -1);
    check_std_a("job1");
    check("job1_bias_low", int'(bias_tr[21:0]), 0);

    // Job 2: start pulsed while busy, bias latched high then toggled.
    bias_cfg = 1'b1;
    exp_q_a.push_back(exp_t'{10, 0});
    exp_q_a.push_back(exp_t'{20, 1});
    run_trace(0, 22, 5, 6);
    check_std_a("job2");
    check("job2_bias_held", int'(bias_tr[21:1]), 21'h1fffff);

    // Job 3: reset in cycle 7 aborts the job.
    run_trace(0, 8, -1, -1);
    check("job3_busy_before_reset", busy_tr[7], 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy_a, 0);
    check("abort_arr_rst", arr_rst_a, 1);
    check("abort_gen_done", gd_a, 0);
    check("abort_done", done_a, 0);
    check("abort_res_valid", res_valid_a, 0);
    check("abort_res_data", int'(res_data_a), 0);
    check("abort_res_row", int'(res_row_a), 0);
    exp_q_a.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Job 4: normal timing after the abort.
    exp_q_a.push_back(exp_t'{10, 0});
    exp_q_a.push_back(exp_t'{20, 1});
    run_trace(0, 22, -1, -1);
    check_std_a("job4");
    check("job4_bias_low", int'(bias_tr[21:0]), 0);

    // M=1: two back-to-back jobs, the second started in the done cycle.
    exp_q_c.push_back(exp_t'{10, 0});
    exp_q_c.push_back(exp_t'{10, 0});
    run_trace(2, 26, 11, -1);
    check("m1_arr_rst_c1", rst_tr[1], 1);
    check("m1_arr_rst_c11", rst_tr[11], 0);
    check("m1_arr_rst_c12", rst_tr[12], 1);
    check("m1_arr_rst_count", $countones(rst_tr), 2);
    check("m1_gd_first", first_one(gd_tr), 2);
    check("m1_gd_tail_c10", gd_tr[10], 1);
    check("m1_gd_c11", gd_tr[11], 0);
    check("m1_gd_count", $countones(gd_tr), 18);
    check("m1_done_c11", done_tr[11], 1);
    check("m1_done_c22", done_tr[22], 1);
    check("m1_done_count", $countones(done_tr), 2);
    check("m1_valid_first", first_one(val_tr), 11);

    // M=4, depth 2, consumer stalled: back-pressure on row boundaries and in TAIL.
    exp_q_b.push_back(exp_t'{10, 0});
    exp_q_b.push_back(exp_t'{20, 1});
    exp_q_b.push_back(exp_t'{30, 2});
    exp_q_b.push_back(exp_t'{40, 3});
    run_trace(1, 50, -1, -1);
    check("stall_gd_c25", gd_tr[25], 1);
    check("stall_gd_c26", gd_tr[26], 0);
    check("stall_gd_c29", gd_tr[29], 0);
    check("stall_gd_c30", gd_tr[30], 1);
    check("stall_gd_c31", gd_tr[31], 1);
    check("stall_gd_c38", gd_tr[38], 0);
    check("stall_gd_c39", gd_tr[39], 0);
    check("stall_gd_c40", gd_tr[40], 1);
    check("stall_gd_count", $countones(gd_tr), 33);
    check("stall_busy_c39", busy_tr[39], 1);
    check("stall_valid_c26", val_tr[26], 1);
    check("stall_done_cycle", first_one(done_tr), 41);
    check("stall_done_count", $countones(done_tr), 1);

    repeat (4) @(negedge clk);
    check("sb_a_drained", exp_q_a.size(), 0);
    check("sb_b_drained", exp_q_b.size(), 0);
    check("sb_c_drained", exp_q_c.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
